seg_scan_driver: RTL

- Downstream of the integrated 4x4 multiplier. Consumes its three 7-segment digit patterns and drives one shared 7-segment bus plus three digit enables by time-multiplexed scanning.
- Double-buffers incoming results so a digit pattern never changes mid-frame.
- Optionally blanks leading zeros, so products such as 9 display as "9" rather than "009".

---
 rtl/seg_scan_driver.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed 3-digit 7-segment scanner
// Double-buffered digit patterns with optional leading-zero blanking.
module seg_scan_driver #(
    parameter int          CLK_DIV    = 4,
    parameter logic [6:0]  ZERO_GLYPH = 7'b0111111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [6:0] seg1_in,
    input  logic [6:0] seg2_in,
    input  logic [6:0] seg3_in,
    input  logic       blank_lz,
    output logic [6:0] seg_out,
    output logic [2:0] an_n,
    output logic       frame_done,
    output logic       pending
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PSC_MAX = PW'(CLK_DIV - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   psc;
    logic [1:0]      idx;
    logic [6:0]      act0, act1, act2;
    logic [6:0]      pb0, pb1, pb2;
    logic            pend_q;
    logic            fd_q;
    logic            frame_end;
    logic [6:0]      seg_sel;
    logic            blank2, blank1;

    // An aborted frame (en low on its last cycle) is not a frame end.
    assign frame_end = (state == SCAN) && en && (idx == 2'd2) && (psc == PSC_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en)  state_nxt = SCAN;
            SCAN:    if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc <= '0;
            idx <= 2'd0;
        end else if (state == SCAN && en) begin
            if (psc == PSC_MAX) begin
                psc <= '0;
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end else begin
                psc <= psc + 1'b1;
            end
        end else begin
            psc <= '0;
            idx <= 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act0   <= '0;
            act1   <= '0;
            act2   <= '0;
            pb0    <= '0;
            pb1    <= '0;
            pb2    <= '0;
            pend_q <= 1'b0;
            fd_q   <= 1'b0;
        end else begin
            fd_q <= frame_end;
            if (frame_end) begin
                // A load on the frame-end cycle bypasses the pending buffer.
                if (load) begin
                    act0 <= seg1_in;
                    act1 <= seg2_in;
                    act2 <= seg3_in;
                end else if (pend_q) begin
                    act0 <= pb0;
                    act1 <= pb1;
                    act2 <= pb2;
                end
                pend_q <= 1'b0;
            end else if (load) begin
                pb0    <= seg1_in;
                pb1    <= seg2_in;
                pb2    <= seg3_in;
                pend_q <= 1'b1;
            end else if (state == IDLE && pend_q) begin
                act0   <= pb0;
                act1   <= pb1;
                act2   <= pb2;
                pend_q <= 1'b0;
            end
        end
    end

    // blank_lz feeds the blanking decode directly so it takes effect at once.
    assign blank2 = blank_lz && (act2 == ZERO_GLYPH);
    assign blank1 = blank2 && (act1 == ZERO_GLYPH);

    always_comb begin
        seg_sel = act0;
        case (idx)
            2'd1:    seg_sel = act1;
            2'd2:    seg_sel = act2;
            default: seg_sel = act0;
        endcase
    end

    always_comb begin
        an_n    = 3'b111;
        seg_out = 7'd0;
        if (state == SCAN) begin
            an_n = ~(3'b001 << idx);
            if (!((idx == 2'd2 && blank2) || (idx == 2'd1 && blank1)))
                seg_out = seg_sel;
        end
    end

    assign frame_done = fd_q;
    assign pending    = pend_q;

endmodule
